// File: rtl/c2s_pkg.sv
// Shared types and constants for the channel-to-target request arbiter.
package c2s_pkg;

    typedef logic [31:0]        uint32_t;
    typedef logic signed [31:0] int32_t;

    localparam int32_t      RET_TIMEOUT        = -32'sd1;
    localparam int unsigned DEFAULT_DATA_WORDS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRsp,
        StAck
    } c2s_state_e;

endpackage

// File: rtl/c2s_rr_arb.sv
// Round-robin grant: picks the first eligible channel after last_grant, wrapping.
module c2s_rr_arb #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] eligible,
    input  logic [CH_W-1:0]   last_grant,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_idx
);

    // last_grant + 1 + off never exceeds 2*NUM_CH-1, so one wrap is enough.
    function automatic logic [CH_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned idx;
        idx = base + off;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        return CH_W'(idx);
    endfunction

    always_comb begin
        logic [CH_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = wrap_idx(32'(last_grant) + 32'd1, i);
            if (!grant_valid && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/c2s_req_arb.sv
// Arbitrates 4-phase channel requests onto a single target command/response port,
// one transaction in flight, with a response timeout.
module c2s_req_arb
    import c2s_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DATA_WORDS  = DEFAULT_DATA_WORDS,
    parameter int unsigned TIMEOUT_CYC = 1024,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYC)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_CH-1:0]                      ch_req,
    output logic [NUM_CH-1:0]                      ch_ack,
    input  uint32_t [NUM_CH-1:0]                   ch_id,
    input  uint32_t [NUM_CH-1:0]                   ch_fn,
    input  uint32_t [NUM_CH-1:0]                   ch_addr,
    input  logic [NUM_CH-1:0][DATA_WORDS-1:0][31:0] ch_data,
    output int32_t [NUM_CH-1:0]                    ch_ret,
    output logic                                   tgt_valid,
    input  logic                                   tgt_ready,
    output logic [CH_W-1:0]                        tgt_ch,
    output uint32_t                                tgt_id,
    output uint32_t                                tgt_fn,
    output uint32_t                                tgt_addr,
    output logic [DATA_WORDS-1:0][31:0]            tgt_data,
    input  logic                                   tgt_rsp_valid,
    input  int32_t                                 tgt_ret,
    output logic                                   busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    c2s_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]         grant_q;
    logic [CH_W-1:0]         last_q;
    int32_t [NUM_CH-1:0]     ret_q;
    logic [NUM_CH-1:0]       eligible;
    logic                    grant_valid;
    logic [CH_W-1:0]         grant_idx;
    logic                    grant_load;
    logic                    ret_load;
    int32_t                  ret_val;

    assign eligible = ch_req & ~ch_ack;

    c2s_rr_arb #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_arb (
        .eligible    (eligible),
        .last_grant  (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_load = 1'b0;
        ret_load   = 1'b0;
        ret_val    = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    grant_load = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                if (tgt_ready) begin
                    cnt_d   = '0;
                    state_d = StWaitRsp;
                end
            end
            StWaitRsp: begin
                // A response arriving in the timeout cycle takes priority.
                if (tgt_rsp_valid) begin
                    ret_load = 1'b1;
                    ret_val  = tgt_ret;
                    state_d  = StAck;
                end else if (cnt_q == CNT_MAX) begin
                    ret_load = 1'b1;
                    ret_val  = RET_TIMEOUT;
                    state_d  = StAck;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StAck: begin
                if (!ch_req[grant_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            grant_q  <= '0;
            last_q   <= CH_W'(NUM_CH - 1);
            tgt_id   <= '0;
            tgt_fn   <= '0;
            tgt_addr <= '0;
            tgt_data <= '0;
            ret_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (grant_load) begin
                grant_q  <= grant_idx;
                last_q   <= grant_idx;
                tgt_id   <= ch_id[grant_idx];
                tgt_fn   <= ch_fn[grant_idx];
                tgt_addr <= ch_addr[grant_idx];
                tgt_data <= ch_data[grant_idx];
            end
            if (ret_load) ret_q[grant_q] <= ret_val;
        end
    end

    always_comb begin
        ch_ack = '0;
        if (state_q == StAck) ch_ack[grant_q] = 1'b1;
    end

    assign ch_ret    = ret_q;
    assign tgt_ch    = grant_q;
    assign tgt_valid = (state_q == StIssue);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_c2s_req_arb.sv
// Directed bench for c2s_req_arb: handshake, fairness, timeout, tie, backpressure, reset.
module tb_c2s_req_arb;
    import c2s_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned TMO = 16;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NCH-1:0]             ch_req;
    logic [NCH-1:0]             ch_ack;
    uint32_t [NCH-1:0]          ch_id, ch_fn, ch_addr;
    logic [NCH-1:0][DW-1:0][31:0] ch_data;
    int32_t [NCH-1:0]           ch_ret;
    logic                       tgt_valid, tgt_ready;
    logic [1:0]                 tgt_ch;
    uint32_t                    tgt_id, tgt_fn, tgt_addr;
    logic [DW-1:0][31:0]        tgt_data;
    logic                       tgt_rsp_valid;
    int32_t                     tgt_ret;
    logic                       busy;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    c2s_req_arb #(
        .NUM_CH      (NCH),
        .DATA_WORDS  (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ch_req        (ch_req),
        .ch_ack        (ch_ack),
        .ch_id         (ch_id),
        .ch_fn         (ch_fn),
        .ch_addr       (ch_addr),
        .ch_data       (ch_data),
        .ch_ret        (ch_ret),
        .tgt_valid     (tgt_valid),
        .tgt_ready     (tgt_ready),
        .tgt_ch        (tgt_ch),
        .tgt_id        (tgt_id),
        .tgt_fn        (tgt_fn),
        .tgt_addr      (tgt_addr),
        .tgt_data      (tgt_data),
        .tgt_rsp_valid (tgt_rsp_valid),
        .tgt_ret       (tgt_ret),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_id(input int unsigned i);
        return 32'h100 + 32'(i);
    endfunction

    function automatic logic [31:0] exp_addr(input int unsigned i);
        return 32'hA000_0000 + (32'(i) << 4);
    endfunction

    function automatic logic [31:0] exp_data(input int unsigned i, input int unsigned w);
        return 32'hD000_0000 | (32'(i) << 8) | 32'(w);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        ch_req        = '0;
        tgt_ready     = 1'b0;
        tgt_rsp_valid = 1'b0;
        tgt_ret       = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_id[i]   = exp_id(i);
            ch_fn[i]   = 32'(i);
            ch_addr[i] = exp_addr(i);
            for (int w = 0; w < DW; w++) ch_data[i][w] = exp_data(i, w);
        end
        ch_fn[0] = 32'd5;

        step(2);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_valid", 32'(tgt_valid), 32'd0);
        chk("rst_ack",   32'(ch_ack), 32'd0);
        chk("rst_ret0",  ch_ret[0], 32'd0);
        chk("rst_tgtch", 32'(tgt_ch), 32'd0);
        chk("rst_id",    tgt_id, 32'd0);
        chk("rst_data",  tgt_data[0], 32'd0);
        rst = 1'b0;
        step(1);

        // Single channel handshake
        ch_req    = 4'b0001;
        tgt_ready = 1'b1;
        step(1);
        chk("s_valid", 32'(tgt_valid), 32'd1);
        chk("s_ch",    32'(tgt_ch), 32'd0);
        chk("s_fn",    tgt_fn, 32'd5);
        chk("s_id",    tgt_id, exp_id(0));
        chk("s_d7",    tgt_data[DW-1], exp_data(0, DW - 1));
        step(1);
        chk("s_accept_valid", 32'(tgt_valid), 32'd0);
        chk("s_wait_busy",    32'(busy), 32'd1);
        chk("s_wait_ack",     32'(ch_ack), 32'd0);
        step(2);
        tgt_rsp_valid = 1'b1;
        tgt_ret       = 32'sd7;
        step(1);
        tgt_rsp_valid = 1'b0;
        chk("s_ack",  32'(ch_ack), 32'h1);
        chk("s_ret0", ch_ret[0], 32'd7);
        ch_req = 4'b0000;
        step(1);
        chk("s_ack_drop", 32'(ch_ack), 32'd0);
        chk("s_idle",     32'(busy), 32'd0);
        // Stray response in IDLE must be ignored
        tgt_rsp_valid = 1'b1;
        tgt_ret       = 32'sd99;
        step(1);
        tgt_rsp_valid = 1'b0;
        chk("stray_ret0", ch_ret[0], 32'd7);
        chk("stray_busy", 32'(busy), 32'd0);

        // Fairness from a fresh reset
        rst = 1'b1;
        step(1);
        rst    = 1'b0;
        ch_req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            int unsigned e;
            e = k % NCH;
            step(1);
            chk("rr_ch", 32'(tgt_ch), 32'(e));
            chk("rr_id", tgt_id, exp_id(e));
            step(1);
            tgt_rsp_valid = 1'b1;
            tgt_ret       = 32'(k + 20);
            step(1);
            tgt_rsp_valid = 1'b0;
            chk("rr_ack", 32'(ch_ack), 32'(1) << e);
            chk("rr_ret", ch_ret[e], 32'(k + 20));
            if (k == 4) chk("rr_hold_ret1", ch_ret[1], 32'd21);
            ch_req[e] = 1'b0;
            step(1);
            chk("rr_ack_drop", 32'(ch_ack), 32'd0);
            ch_req[e] = 1'b1;
        end
        ch_req = '0;
        step(1);

        // Timeout
        ch_req = 4'b0001;
        step(1);
        chk("to_ch", 32'(tgt_ch), 32'd0);
        step(1);
        step(TMO - 1);
        chk("to_pre_ack",  32'(ch_ack), 32'd0);
        chk("to_pre_busy", 32'(busy), 32'd1);
        step(1);
        chk("to_ack", 32'(ch_ack), 32'h1);
        chk("to_ret", ch_ret[0], 32'hFFFF_FFFF);
        ch_req = '0;
        step(1);
        chk("to_idle", 32'(busy), 32'd0);

        // Response in the timeout cycle wins
        ch_req = 4'b0001;
        step(1);
        step(1);
        step(TMO - 1);
        tgt_rsp_valid = 1'b1;
        tgt_ret       = 32'sd3;
        step(1);
        tgt_rsp_valid = 1'b0;
        chk("tie_ack", 32'(ch_ack), 32'h1);
        chk("tie_ret", ch_ret[0], 32'd3);
        ch_req = '0;
        step(1);

        // Backpressure: latched command must not follow changing channel inputs
        tgt_ready = 1'b0;
        ch_req    = 4'b0100;
        step(1);
        chk("bp_ch", 32'(tgt_ch), 32'd2);
        ch_data[2][0] = 32'h0;
        ch_addr[2]    = 32'h0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            chk("bp_valid", 32'(tgt_valid), 32'd1);
            chk("bp_data0", tgt_data[0], exp_data(2, 0));
            chk("bp_addr",  tgt_addr, exp_addr(2));
        end
        ch_data[2][0] = exp_data(2, 0);
        ch_addr[2]    = exp_addr(2);
        tgt_ready     = 1'b1;
        step(1);
        chk("bp_accept", 32'(tgt_valid), 32'd0);
        step(3);

        // Asynchronous reset during WAIT_RSP
        rst = 1'b1;
        #1;
        chk("ar_busy",  32'(busy), 32'd0);
        chk("ar_valid", 32'(tgt_valid), 32'd0);
        chk("ar_ack",   32'(ch_ack), 32'd0);
        chk("ar_ch",    32'(tgt_ch), 32'd0);
        chk("ar_id",    tgt_id, 32'd0);
        chk("ar_data",  tgt_data[0], 32'd0);
        chk("ar_ret0",  ch_ret[0], 32'd0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("re_valid", 32'(tgt_valid), 32'd1);
        chk("re_ch",    32'(tgt_ch), 32'd2);
        chk("re_id",    tgt_id, exp_id(2));
        chk("re_ack",   32'(ch_ack), 32'd0);
        step(1);
        tgt_rsp_valid = 1'b1;
        tgt_ret       = 32'sh55;
        step(1);
        tgt_rsp_valid = 1'b0;
        chk("re_ack2", 32'(ch_ack), 32'h4);
        chk("re_ret2", ch_ret[2], 32'h55);
        ch_req = '0;
        step(1);
        chk("re_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
